sram_scan_reader: RTL and testbench

- Upstream address sequencer and downstream consumer for the 1-bit-wide, combinational-read SRAM cell array.
- On a start pulse it drives the addresses 0..DEPTH-1 in turn and samples the 1-bit read data each cycle.
- It packs the bits into a DEPTH-bit word, counts the ones, and presents the result on a valid/ready output handshake.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_scan_reader.sv | 109 ++++++++++
 tb/tb_sram_scan_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and default geometry for the 1-bit SRAM cell array
// and the scan reader that walks it.
package sram_pkg;

    localparam int SRAM_ADDR_W = 2;
    localparam int SRAM_DEPTH  = 4;
    localparam int SRAM_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sram_scan_reader.sv
// Walks SRAM addresses 0..DEPTH-1, packs the read bits into a word,
// counts the ones and offers the result on a valid/ready handshake.
module sram_scan_reader
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DEPTH  = SRAM_DEPTH,
    parameter int CNT_W  = SRAM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_dout,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DEPTH-1:0]  out_word,
    output logic [CNT_W-1:0]  out_ones
);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0]  acc_word_q, acc_word_d;
    logic [CNT_W-1:0]  acc_ones_q, acc_ones_d;
    logic [DEPTH-1:0]  word_q, word_d;
    logic [CNT_W-1:0]  ones_q, ones_d;

    logic [DEPTH-1:0]  cap_word;
    logic [CNT_W-1:0]  cap_ones;
    logic              last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            acc_word_q <= '0;
            acc_ones_q <= '0;
            word_q     <= '0;
            ones_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            acc_word_q <= acc_word_d;
            acc_ones_q <= acc_ones_d;
            word_q     <= word_d;
            ones_q     <= ones_d;
        end
    end

    // Accumulator contents including the bit read this cycle.
    always_comb begin
        cap_word = acc_word_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                cap_word[i] = mem_dout;
            end
        end
        cap_ones = acc_ones_q + CNT_W'(mem_dout);
        last     = (addr_q == ADDR_W'(DEPTH - 1));
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        acc_word_d = acc_word_q;
        acc_ones_d = acc_ones_q;
        word_d     = word_q;
        ones_d     = ones_q;
        unique case (state_q)
            IDLE: begin
                addr_d     = '0;
                acc_word_d = '0;
                acc_ones_d = '0;
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_word_d = cap_word;
                acc_ones_d = cap_ones;
                if (last) begin
                    state_d = HOLD;
                    addr_d  = '0;
                    word_d  = cap_word;
                    ones_d  = cap_ones;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_word  = word_q;
    assign out_ones  = ones_q;

endmodule

// File: tb/tb_sram_scan_reader.sv
// Directed bench for sram_scan_reader paired with a behavioural
// 4x1 combinational-read SRAM array.
module tb_sram_scan_reader;
    import sram_pkg::*;

    localparam int AW = SRAM_ADDR_W;
    localparam int DP = SRAM_DEPTH;
    localparam int CW = SRAM_CNT_W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic          mem_dout;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [DP-1:0] out_word;
    logic [CW-1:0] out_ones;

    logic [DP-1:0] mem;

    int total;
    int bad;

    assign mem_dout = mem[mem_addr];

    sram_scan_reader #(
        .ADDR_W(AW),
        .DEPTH (DP),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_ones (out_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start in IDLE, follow the scan, stop in the first HOLD cycle.
    task automatic run_scan(input string tag,
                            input logic [DP-1:0] ew,
                            input logic [CW-1:0] eo);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DP; i++) begin
            chk({tag, "_addr"}, 32'(mem_addr), 32'(i));
            chk({tag, "_vld_scan"}, 32'(out_valid), 32'd0);
            chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
            tick();
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_word"}, 32'(out_word), 32'(ew));
        chk({tag, "_ones"}, 32'(out_ones), 32'(eo));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        mem       = 4'b1010;

        // reset
        tick();
        tick();
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_word", 32'(out_word), 32'd0);
        chk("rst_ones", 32'(out_ones), 32'd0);
        rst = 1'b0;

        // basic scan
        run_scan("basic", 4'b1010, 3'd2);
        tick();
        chk("basic_vld_after", 32'(out_valid), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_word_kept", 32'(out_word), 32'hA);

        // backpressure
        out_ready = 1'b0;
        run_scan("bp", 4'b1010, 3'd2);
        for (int i = 0; i < 6; i++) begin
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_word", 32'(out_word), 32'hA);
            chk("bp_ones", 32'(out_ones), 32'd2);
            chk("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_vld_last", 32'(out_valid), 32'd1);
        tick();
        chk("bp_vld_done", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);
        tick();
        chk("bp_one_hs", 32'(out_valid), 32'd0);
        chk("bp_still_idle", 32'(busy), 32'd0);

        // start ignored in SCAN and on the handshake edge
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        chk("ign_addr_c2", 32'(mem_addr), 32'd1);
        tick();
        start = 1'b0;
        chk("ign_addr_c3", 32'(mem_addr), 32'd2);
        tick();
        tick();
        chk("ign_vld", 32'(out_valid), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ign_busy", 32'(busy), 32'd0);
            chk("ign_addr", 32'(mem_addr), 32'd0);
            chk("ign_vld_lo", 32'(out_valid), 32'd0);
            tick();
        end
        run_scan("ign_again", 4'b1010, 3'd2);
        tick();

        // reset during SCAN cycle 3
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_addr", 32'(mem_addr), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_vld", 32'(out_valid), 32'd0);
        chk("mid_word", 32'(out_word), 32'd0);
        chk("mid_ones", 32'(out_ones), 32'd0);
        tick();
        chk("mid_stay_idle", 32'(busy), 32'd0);
        run_scan("mid_fresh", 4'b1010, 3'd2);
        tick();

        // alternate contents
        mem = 4'hF;
        run_scan("all1", 4'hF, 3'd4);
        tick();
        mem = 4'h0;
        run_scan("all0", 4'h0, 3'd0);
        tick();

        // back-to-back: restart in the first IDLE cycle
        mem = 4'b0110;
        run_scan("b2b_a", 4'b0110, 3'd2);
        tick();
        chk("b2b_idle", 32'(busy), 32'd0);
        run_scan("b2b_b", 4'b0110, 3'd2);
        tick();
        chk("b2b_end", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
